gearbox_32_24: RTL and testbench

//  Reverse of gearbox_24_32: unpacks a stream of 32-bit words back into 24-bit RGB pixels.

---
 rtl/gearbox_32_24.sv | 120 ++++++++++++
 tb/tb_gearbox_32_24.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_32_24.sv
// Unpacks an LSB-first stream of 32-bit words into 24-bit {B,G,R} pixels.
// Input is throttled through data_in_ready because output bandwidth (24 b/clk) is below input (32 b/clk).
module gearbox_32_24 #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_in_last,
  input  logic [1:0]  data_in_bytes,
  input  logic        data_en,
  output logic        data_in_ready,
  output logic [23:0] data_out,
  output logic        data_out_last,
  output logic        data_out_en,
  output logic        residue_err
);

  logic [55:0] buf_q, buf_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        pend_last_q, pend_last_d;
  logic [23:0] data_out_q, data_out_d;
  logic        data_out_last_q, data_out_last_d;
  logic        data_out_en_q, data_out_en_d;
  logic        residue_err_q, residue_err_d;

  logic        accept;
  logic [2:0]  nb_bytes;
  logic [31:0] in_mask;
  logic [55:0] combined;
  logic [5:0]  total;
  logic        pend_any;

  assign data_in_ready = (cnt_q <= 6'd24) && !pend_last_q;
  assign accept        = data_en && data_in_ready;
  assign pend_any      = pend_last_q || (accept && data_in_last);

  always_comb begin
    nb_bytes = 3'd0;
    in_mask  = 32'h0;
    if (accept) begin
      if (data_in_last && (data_in_bytes != 2'd0)) begin
        nb_bytes = {1'b0, data_in_bytes};
      end else begin
        nb_bytes = 3'd4;
      end
      case (nb_bytes)
        3'd1:    in_mask = 32'h0000_00FF;
        3'd2:    in_mask = 32'h0000_FFFF;
        3'd3:    in_mask = 32'h00FF_FFFF;
        default: in_mask = 32'hFFFF_FFFF;
      endcase
    end
  end

  // Buffer bits above cnt are always zero, so new bytes can simply be OR-ed in at cnt.
  assign combined = buf_q | ({24'h0, data_in & in_mask} << cnt_q);
  assign total    = cnt_q + {nb_bytes, 3'b000};

  always_comb begin
    buf_d           = combined;
    cnt_d           = total;
    pend_last_d     = pend_any;
    data_out_d      = data_out_q;
    data_out_en_d   = 1'b0;
    data_out_last_d = 1'b0;
    residue_err_d   = 1'b0;
    if (total >= 6'd24) begin
      data_out_d    = combined[23:0];
      buf_d         = combined >> 24;
      cnt_d         = total - 6'd24;
      data_out_en_d = 1'b1;
      if ((total == 6'd24) && pend_any) begin
        data_out_last_d = 1'b1;
        pend_last_d     = 1'b0;
      end
    end else if (pend_last_q) begin
      // Packet ended mid-pixel: flush what is left, padded, and flag it.
      buf_d       = 56'h0;
      cnt_d       = 6'd0;
      pend_last_d = 1'b0;
      if (total != 6'd0) begin
        data_out_en_d   = 1'b1;
        data_out_last_d = 1'b1;
        residue_err_d   = 1'b1;
        case (cnt_q[4:3])
          2'd1:    data_out_d = {PAD_BYTE, PAD_BYTE, buf_q[7:0]};
          2'd2:    data_out_d = {PAD_BYTE, buf_q[15:0]};
          default: data_out_d = buf_q[23:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q           <= 56'h0;
      cnt_q           <= 6'd0;
      pend_last_q     <= 1'b0;
      data_out_q      <= 24'h0;
      data_out_last_q <= 1'b0;
      data_out_en_q   <= 1'b0;
      residue_err_q   <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      cnt_q           <= cnt_d;
      pend_last_q     <= pend_last_d;
      data_out_q      <= data_out_d;
      data_out_last_q <= data_out_last_d;
      data_out_en_q   <= data_out_en_d;
      residue_err_q   <= residue_err_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_out_last = data_out_last_q;
  assign data_out_en   = data_out_en_q;
  assign residue_err   = residue_err_q;

endmodule

// File: tb/tb_gearbox_32_24.sv
// Directed bench for gearbox_32_24: packets of hand-chosen words, pixels checked against hand-derived values.
module tb_gearbox_32_24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic        data_in_last = 1'b0;
  logic [1:0]  data_in_bytes = 2'd0;
  logic        data_en = 1'b0;
  logic        data_in_ready;
  logic [23:0] data_out;
  logic        data_out_last;
  logic        data_out_en;
  logic        residue_err;

  gearbox_32_24 #(.PAD_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_last(data_in_last),
    .data_in_bytes(data_in_bytes), .data_en(data_en), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_last(data_out_last), .data_out_en(data_out_en),
    .residue_err(residue_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0, stray = 0, acc_cyc = 0;
  logic [31:0] words [0:15];
  logic [23:0] exp_px [0:15];
  logic [23:0] px_q [$];
  logic        lst_q [$];
  logic        res_q [$];
  int          pcyc_q [$];
  logic        rdy_log [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_out_en) begin
        px_q.push_back(data_out);
        lst_q.push_back(data_out_last);
        res_q.push_back(residue_err);
        pcyc_q.push_back(cyc);
      end else if (data_out_last || residue_err) begin
        stray++;
      end
    end
  end

  task automatic clear_mon();
    px_q.delete(); lst_q.delete(); res_q.delete(); pcyc_q.delete(); rdy_log.delete();
  endtask

  task automatic send_packet(input int n, input logic [1:0] lb, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin @(negedge clk); data_en = 1'b0; end
      guard = 0;
      do begin
        @(negedge clk);
        data_in = words[i]; data_en = 1'b1;
        data_in_last = (i == n-1); data_in_bytes = (i == n-1) ? lb : 2'd0;
        rdy_log.push_back(data_in_ready);
        guard++;
      end while (!data_in_ready && guard < 20);
      vectors++;
      if (data_in_ready !== 1'b1) begin
        $display("FAIL send_ready word %0d: ready=%b required 1", i, data_in_ready);
        miscompares++;
      end
      acc_cyc = cyc;
    end
    @(negedge clk);
    data_en = 1'b0; data_in_last = 1'b0; data_in_bytes = 2'd0;
  endtask

  task automatic wait_pixels(input int n, input string nm);
    int t = 0;
    while (px_q.size() < n && t < 200) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    vectors++;
    if (px_q.size() != n) begin
      $display("FAIL %s pixel_count got %0d required %0d", nm, px_q.size(), n);
      miscompares++;
    end
  endtask

  task automatic load_basic();
    words[0] = 32'h44332211; words[1] = 32'h88776655; words[2] = 32'hCCBBAA99;
    exp_px[0] = 24'h332211; exp_px[1] = 24'h665544; exp_px[2] = 24'h998877; exp_px[3] = 24'hCCBBAA;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({data_in_ready, data_out, data_out_last, data_out_en, residue_err} !== {1'b1, 24'h0, 3'b000}) begin
      $display("FAIL reset_state got rdy=%b out=%h last=%b en=%b res=%b", data_in_ready, data_out,
               data_out_last, data_out_en, residue_err);
      miscompares++;
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_mon(); load_basic();
    send_packet(3, 2'd0, 0);
    wait_pixels(4, "basic");
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      vectors++;
      if (px_q[i] !== exp_px[i]) begin
        $display("FAIL basic_px%0d got %h required %h", i, px_q[i], exp_px[i]); miscompares++;
      end
      vectors++;
      if (lst_q[i] !== (i == 3) || res_q[i] !== 1'b0) begin
        $display("FAIL basic_flags%0d got last=%b res=%b required last=%b res=0", i, lst_q[i], res_q[i], i == 3);
        miscompares++;
      end
    end
  endtask

  task automatic test_continuous();
    logic exp_rdy;
    clear_mon();
    for (int k = 0; k < 48; k++) words[k/4][8*(k%4) +: 8] = 8'(k + 1);
    send_packet(12, 2'd0, 0);
    wait_pixels(16, "cont");
    vectors++;
    if (rdy_log.size() != 15) begin
      $display("FAIL cont_ready_len got %0d required 15", rdy_log.size()); miscompares++;
    end
    for (int k = 0; k < 15 && k < rdy_log.size(); k++) begin
      exp_rdy = (k < 4) ? 1'b1 : (((k - 4) % 4) != 0);
      vectors++;
      if (rdy_log[k] !== exp_rdy) begin
        $display("FAIL cont_ready%0d got %b required %b", k, rdy_log[k], exp_rdy); miscompares++;
      end
    end
    for (int j = 0; j < 16 && j < px_q.size(); j++) begin
      vectors++;
      if (px_q[j] !== {8'(3*j+3), 8'(3*j+2), 8'(3*j+1)}) begin
        $display("FAIL cont_px%0d got %h required %h", j, px_q[j], {8'(3*j+3), 8'(3*j+2), 8'(3*j+1)});
        miscompares++;
      end
      vectors++;
      if (lst_q[j] !== (j == 15) || res_q[j] !== 1'b0 || pcyc_q[j] != pcyc_q[0] + j) begin
        $display("FAIL cont_flags%0d got last=%b res=%b cyc_off=%0d required last=%b res=0 cyc_off=%0d",
                 j, lst_q[j], res_q[j], pcyc_q[j] - pcyc_q[0], j == 15, j);
        miscompares++;
      end
    end
  endtask

  task automatic test_single_3byte();
    clear_mon();
    words[0] = 32'h00DDCCBB;
    send_packet(1, 2'd3, 0);
    wait_pixels(1, "single3");
    if (px_q.size() > 0) begin
      vectors++;
      if (px_q[0] !== 24'hDDCCBB || lst_q[0] !== 1'b1 || res_q[0] !== 1'b0) begin
        $display("FAIL single3 got %h last=%b res=%b required DDCCBB last=1 res=0", px_q[0], lst_q[0], res_q[0]);
        miscompares++;
      end
      vectors++;
      if (pcyc_q[0] != acc_cyc + 1) begin
        $display("FAIL single3_latency got %0d required 1", pcyc_q[0] - acc_cyc); miscompares++;
      end
    end
  endtask

  task automatic test_residue();
    clear_mon();
    words[0] = 32'hAABBCCDD;
    send_packet(1, 2'd0, 0);
    wait_pixels(2, "residue");
    if (px_q.size() > 1) begin
      vectors++;
      if (px_q[0] !== 24'hBBCCDD || lst_q[0] !== 1'b0 || res_q[0] !== 1'b0) begin
        $display("FAIL residue_px0 got %h last=%b res=%b required BBCCDD last=0 res=0", px_q[0], lst_q[0], res_q[0]);
        miscompares++;
      end
      vectors++;
      if (px_q[1] !== 24'h0000AA || lst_q[1] !== 1'b1 || res_q[1] !== 1'b1) begin
        $display("FAIL residue_px1 got %h last=%b res=%b required 0000AA last=1 res=1", px_q[1], lst_q[1], res_q[1]);
        miscompares++;
      end
    end
    // Two-byte last word: upper input bytes must be ignored, tail padded.
    clear_mon();
    words[0] = 32'hFFFF2211;
    send_packet(1, 2'd2, 0);
    wait_pixels(1, "short2");
    if (px_q.size() > 0) begin
      vectors++;
      if (px_q[0] !== 24'h002211 || lst_q[0] !== 1'b1 || res_q[0] !== 1'b1) begin
        $display("FAIL short2 got %h last=%b res=%b required 002211 last=1 res=1", px_q[0], lst_q[0], res_q[0]);
        miscompares++;
      end
    end
  endtask

  task automatic test_intermittent();
    clear_mon();
    for (int k = 0; k < 24; k++) words[k/4][8*(k%4) +: 8] = 8'(8'h40 + k);
    send_packet(6, 2'd0, 2);
    wait_pixels(8, "interm");
    for (int j = 0; j < 8 && j < px_q.size(); j++) begin
      vectors++;
      if (px_q[j] !== {8'(8'h42 + 3*j), 8'(8'h41 + 3*j), 8'(8'h40 + 3*j)} || lst_q[j] !== (j == 7) || res_q[j] !== 1'b0) begin
        $display("FAIL interm_px%0d got %h last=%b res=%b required %h last=%b res=0", j, px_q[j], lst_q[j], res_q[j],
                 {8'(8'h42 + 3*j), 8'(8'h41 + 3*j), 8'(8'h40 + 3*j)}, j == 7);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_midpacket();
    clear_mon();
    @(negedge clk); data_in = 32'h04030201; data_en = 1'b1; data_in_last = 1'b0;
    @(negedge clk); data_in = 32'h08070605; data_in_last = 1'b1; data_in_bytes = 2'd0;
    @(negedge clk); data_en = 1'b0; data_in_last = 1'b0;
    vectors++;
    if (data_in_ready !== 1'b0 || data_out !== 24'h060504) begin
      $display("FAIL midpkt_pre got rdy=%b out=%h required rdy=0 out=060504", data_in_ready, data_out);
      miscompares++;
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({data_in_ready, data_out, data_out_last, data_out_en, residue_err} !== {1'b1, 24'h0, 3'b000}) begin
      $display("FAIL midpkt_reset got rdy=%b out=%h last=%b en=%b res=%b", data_in_ready, data_out,
               data_out_last, data_out_en, residue_err);
      miscompares++;
    end
    @(negedge clk); reset = 1'b0;
    clear_mon(); load_basic();
    send_packet(3, 2'd0, 0);
    wait_pixels(4, "after_reset");
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      vectors++;
      if (px_q[i] !== exp_px[i] || lst_q[i] !== (i == 3) || res_q[i] !== 1'b0) begin
        $display("FAIL after_reset_px%0d got %h last=%b res=%b required %h last=%b res=0", i, px_q[i], lst_q[i],
                 res_q[i], exp_px[i], i == 3);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_single_3byte();
    test_residue();
    test_intermittent();
    test_reset_midpacket();
    vectors++;
    if (stray != 0) begin
      $display("FAIL stray_flags got %0d required 0", stray); miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
